// File: rtl/key_conditioner_if.sv
// Key bus between raw buttons and the conditioner: raw active-low keys in,
// debounced level and single-cycle press/release pulses out.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per key a 2-FF synchronizer, a counter debounce and
// a four-state FSM producing a clean level plus one-cycle press/release pulses.
module key_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press,
    output logic rls
);
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              s1, s2;
    logic              p;
    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              level_d, press_d, rls_d;

    // Synchronizer resets to the released level so a held key is re-debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    assign p = ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            level <= level_d;
            press <= press_d;
            rls   <= rls_d;
        end
    end

    // Counter restarts on every transition, so it never passes CNT_MAX.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = level;
        press_d = 1'b0;
        rls_d   = 1'b0;
        case (state)
            IDLE: begin
                if (p) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (p) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rls_d   = 1'b1;
                end else begin
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end
endmodule

module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic               clk,
    input  logic               rst,
    key_conditioner_if.slave   kif
);
    logic [NUM_KEYS-1:0] level, press, rls;

    // Channels share nothing but the clock and reset.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .key_raw (kif.key_n[k]),
            .level   (level[k]),
            .press   (press[k]),
            .rls     (rls[k])
        );
    end

    assign kif.key_level   = level;
    assign kif.key_press   = press;
    assign kif.key_release = rls;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with an 8-sample debounce: vector table, hand-written
// corner sequences and a random phase compared against a run-length model.
module tb_key_conditioner;
    localparam int NK  = 4;
    localparam int DEB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   mdl_on = 1'b0;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: the key's pressed sample is key_n delayed two clocks; a level flips
    // once DEB consecutive samples disagree with it.
    logic [NK-1:0] m_s1 = '1, m_s2 = '1, m_p;
    logic [NK-1:0] m_level = '0, m_press = '0, m_rel = '0;
    int            m_run [NK];

    always @(posedge clk) begin
        m_p  = ~m_s2;
        m_s2 = m_s1;
        m_s1 = kif.key_n;
        for (int k = 0; k < NK; k++) begin
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            if (rst) begin
                m_run[k]   = 0;
                m_level[k] = 1'b0;
            end else if (m_p[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_level[k] = m_p[k];
                    m_press[k] = m_p[k];
                    m_rel[k]   = ~m_p[k];
                    m_run[k]   = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        if (rst) begin
            m_s1 = '1;
            m_s2 = '1;
        end
    end

    always @(negedge clk) begin
        if (mdl_on)
            chk("model", 16'({kif.key_level, kif.key_press, kif.key_release}),
                16'({m_level, m_press, m_rel}));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        kif.key_n = '1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [NK-1:0] key_n;
        int            ticks;
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t vt [12];
    int   np [NK];
    int   nr [NK];

    initial begin
        vt[0]  = '{1'b1, 4'hF, 2,  4'h0, 4'h0, 4'h0};  // reset state
        vt[1]  = '{1'b0, 4'hE, 9,  4'h0, 4'h0, 4'h0};  // edges E0..E8: still waiting
        vt[2]  = '{1'b0, 4'hE, 1,  4'h1, 4'h1, 4'h0};  // E9: press
        vt[3]  = '{1'b0, 4'hE, 1,  4'h1, 4'h0, 4'h0};  // pulse is one cycle
        vt[4]  = '{1'b0, 4'hF, 9,  4'h1, 4'h0, 4'h0};  // release waiting
        vt[5]  = '{1'b0, 4'hF, 1,  4'h0, 4'h0, 4'h1};  // release pulse
        vt[6]  = '{1'b0, 4'hF, 1,  4'h0, 4'h0, 4'h0};
        vt[7]  = '{1'b0, 4'h5, 10, 4'hA, 4'hA, 4'h0};  // keys 1 and 3 together
        vt[8]  = '{1'b1, 4'h5, 1,  4'h0, 4'h0, 4'h0};  // reset while held: no release
        vt[9]  = '{1'b0, 4'h5, 10, 4'hA, 4'hA, 4'h0};  // held through reset re-presses
        vt[10] = '{1'b0, 4'hF, 10, 4'h0, 4'h0, 4'hA};
        vt[11] = '{1'b0, 4'hF, 1,  4'h0, 4'h0, 4'h0};

        kif.key_n = '1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            rst       = vt[i].rst;
            kif.key_n = vt[i].key_n;
            repeat (vt[i].ticks) tick();
            chk($sformatf("vec%0d", i),
                16'({kif.key_level, kif.key_press, kif.key_release}),
                16'({vt[i].level, vt[i].press, vt[i].rel}));
            mdl_on = 1'b1;
        end

        // Clean press on key 2: pulse only after edge E9.
        do_reset();
        kif.key_n[2] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("t1 c%0d", c), 16'({kif.key_level[2], kif.key_press[2]}),
                16'({c >= 9, c == 9}));
        end

        // Bounce on key 0: low 5, high 1, low 12.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            kif.key_n[0] = (c == 5);
            tick();
            chk($sformatf("t2 c%0d", c), 16'(kif.key_press[0]), 16'(c == 15));
        end
        kif.key_n = '1;
        repeat (12) tick();

        // Release of key 1 with a 3-cycle glitch back low.
        do_reset();
        kif.key_n[1] = 1'b0;
        repeat (12) tick();
        for (int c = 0; c < 21; c++) begin
            kif.key_n[1] = !(c >= 4 && c <= 6);
            tick();
            chk($sformatf("t3 c%0d", c), 16'({kif.key_level[1], kif.key_release[1]}),
                16'({c < 16, c == 16}));
        end

        // Reset in the middle of key 3's debounce.
        do_reset();
        kif.key_n[3] = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk("t4 rst", 16'({kif.key_level, kif.key_press, kif.key_release}), 16'(0));
        rst = 1'b0;
        for (int c = 8; c < 21; c++) begin
            tick();
            chk($sformatf("t4 c%0d", c), 16'({kif.key_level[3], kif.key_press[3]}),
                16'({c >= 17, c == 17}));
        end
        kif.key_n = '1;
        repeat (12) tick();

        // All keys on one edge, then held for 1000 cycles.
        do_reset();
        for (int k = 0; k < NK; k++) begin
            np[k] = 0;
            nr[k] = 0;
        end
        kif.key_n = '0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            for (int k = 0; k < NK; k++) begin
                np[k] += int'(kif.key_press[k]);
                nr[k] += int'(kif.key_release[k]);
            end
            if (c == 9)  chk("t5 press", 16'(kif.key_press), 16'hF);
            if (c == 10) chk("t5 after", 16'({kif.key_level, kif.key_press}), 16'hF0);
        end
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("t6 npress%0d", k), 16'(np[k]), 16'd1);
            chk($sformatf("t6 nrel%0d", k), 16'(nr[k]), 16'd0);
        end
        kif.key_n = '1;
        repeat (12) begin
            tick();
            for (int k = 0; k < NK; k++) nr[k] += int'(kif.key_release[k]);
        end
        for (int k = 0; k < NK; k++)
            chk($sformatf("t6 rel%0d", k), 16'(nr[k]), 16'd1);

        // Random bouncing and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(11) == 0) kif.key_n[k] = ~kif.key_n[k];
            rst = ($urandom_range(399) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
